// File: rtl/dump_sequencer_pkg.sv
// Shared debug-unit encodings: dump sequencer FSM states and frame sections.
package dump_sequencer_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Frame sections, sent in this order
  localparam logic [1:0] SEC_PC  = 2'd0;
  localparam logic [1:0] SEC_REG = 2'd1;
  localparam logic [1:0] SEC_MEM = 2'd2;

endpackage

// File: rtl/dump_sequencer.sv
// Dump sequencer: streams PC, register file and data memory, one word at a
// time, to an external UART word serializer.
module dump_sequencer
  import dump_sequencer_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned ADDR_LEN  = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [DATA_LEN-1:0] i_pc,
  output logic [ADDR_LEN-1:0] o_reg_addr,
  input  logic [DATA_LEN-1:0] i_reg_data,
  output logic [ADDR_LEN-1:0] o_mem_addr,
  input  logic [DATA_LEN-1:0] i_mem_data,
  output logic                o_wr,
  output logic [DATA_LEN-1:0] o_wr_data,
  input  logic                i_wr_finished,
  output logic                o_busy,
  output logic                o_done
);

  typedef logic [ADDR_LEN:0] idx_t;

  localparam idx_t REG_LAST = idx_t'((REG_COUNT == 0) ? 0 : REG_COUNT - 1);
  localparam idx_t MEM_LAST = idx_t'((MEM_WORDS == 0) ? 0 : MEM_WORDS - 1);

  logic [2:0]          r_state;
  logic [1:0]          r_section;
  idx_t                r_index;
  logic [ADDR_LEN-1:0] r_reg_addr;
  logic [ADDR_LEN-1:0] r_mem_addr;
  logic                r_wr;
  logic [DATA_LEN-1:0] r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_fin_prev;

  logic [2:0]          w_next_state;
  logic [1:0]          w_next_section;
  idx_t                w_next_index;
  logic                w_fin_rise;
  logic [DATA_LEN-1:0] w_load_data;

  // A level already high when WAIT is entered has a high registered copy, so
  // only a genuine 0->1 transition completes the word.
  assign w_fin_rise = i_wr_finished & ~r_fin_prev;

  // Next state, section and index; NEXT walks PC -> REG -> MEM, skipping empty sections
  always_comb begin
    w_next_state   = r_state;
    w_next_section = r_section;
    w_next_index   = r_index;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state   = ST_SETUP;
          w_next_section = SEC_PC;
          w_next_index   = '0;
        end
      end
      ST_SETUP: w_next_state = ST_LOAD;
      ST_LOAD:  w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (w_fin_rise) w_next_state = ST_NEXT;
      end
      ST_NEXT: begin
        w_next_state = ST_SETUP;
        w_next_index = '0;
        case (r_section)
          SEC_PC: begin
            if (REG_COUNT != 0)      w_next_section = SEC_REG;
            else if (MEM_WORDS != 0) w_next_section = SEC_MEM;
            else                     w_next_state   = ST_DONE;
          end
          SEC_REG: begin
            if (r_index < REG_LAST)  w_next_index   = r_index + idx_t'(1);
            else if (MEM_WORDS != 0) w_next_section = SEC_MEM;
            else                     w_next_state   = ST_DONE;
          end
          SEC_MEM: begin
            if (r_index < MEM_LAST) w_next_index = r_index + idx_t'(1);
            else                    w_next_state = ST_DONE;
          end
          default: w_next_state = ST_DONE;
        endcase
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Word source for the current section
  always_comb begin
    w_load_data = i_pc;
    case (r_section)
      SEC_REG: w_load_data = i_reg_data;
      SEC_MEM: w_load_data = i_mem_data;
      default: w_load_data = i_pc;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_section  <= SEC_PC;
      r_index    <= '0;
      r_reg_addr <= '0;
      r_mem_addr <= '0;
      r_wr       <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fin_prev <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_section  <= w_next_section;
      r_index    <= w_next_index;
      r_fin_prev <= i_wr_finished;
      // Addresses are loaded on entry to SETUP so they are presented for the
      // whole SETUP cycle; the synchronous read data is then valid in LOAD.
      if (w_next_state == ST_SETUP) begin
        r_reg_addr <= w_next_index[ADDR_LEN-1:0];
        r_mem_addr <= w_next_index[ADDR_LEN-1:0];
      end
      r_wr <= (r_state == ST_LOAD);
      if (r_state == ST_LOAD) r_wr_data <= w_load_data;
      r_busy <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  assign o_reg_addr = r_reg_addr;
  assign o_mem_addr = r_mem_addr;
  assign o_wr       = r_wr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameter DATA_LEN, default 32, width of every dumped word and of o_wr_data.
REQ-002 Parameter REG_COUNT, default 32, number of register-file words dumped.
REQ-003 Parameter MEM_WORDS, default 32, number of data-memory words dumped.
REQ-004 Parameter ADDR_LEN, default 5, width of o_reg_addr and o_mem_addr; SHALL satisfy 2^ADDR_LEN >= max(REG_COUNT, MEM_WORDS).
REQ-005 i_clk  in  1  single clock; all state changes on rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  request one full dump frame; sampled only in IDLE.
REQ-008 i_pc  in  DATA_LEN  current program counter.
REQ-009 o_reg_addr  out  ADDR_LEN  register-file read address.
REQ-010 i_reg_data  in  DATA_LEN  register-file read data, valid one cycle after o_reg_addr.
REQ-011 o_mem_addr  out  ADDR_LEN  data-memory word read address.
REQ-012 i_mem_data  in  DATA_LEN  data-memory read data, valid one cycle after o_mem_addr.
REQ-013 o_wr  out  1  one-cycle start pulse to the UART word serializer.
REQ-014 o_wr_data  out  DATA_LEN  word for the serializer; stable for the whole transfer.
REQ-015 i_wr_finished  in  1  serializer completion level; a word is complete on its 0->1 transition.
REQ-016 o_busy  out  1  high from the cycle after an accepted i_start until DONE.
REQ-017 o_done  out  1  one-cycle pulse when the frame is fully sent.

Function
REQ-018 Frame order SHALL be: i_pc, registers 0..REG_COUNT-1, memory words 0..MEM_WORDS-1; total 1+REG_COUNT+MEM_WORDS words, lowest index first.
REQ-019 States SHALL be IDLE, SETUP, LOAD, WAIT, NEXT, DONE; section register values PC, REG, MEM; index counter ADDR_LEN+1 bits.
REQ-020 IDLE: on i_start=1, go to SETUP with section=PC, index=0; otherwise stay.
REQ-021 SETUP: drive o_reg_addr/o_mem_addr from index (both driven regardless of section); one cycle; go to LOAD.
REQ-022 LOAD: register o_wr_data from i_pc, i_reg_data or i_mem_data per section; set o_wr=1 for exactly the next cycle; go to WAIT.
REQ-023 WAIT: hold o_wr_data; stay until rising edge of i_wr_finished (current=1, previous-cycle registered copy=0); then go to NEXT.
REQ-024 A finished level already high on entry to WAIT SHALL NOT count as completion.
REQ-025 NEXT: PC -> REG index 0 (MEM if REG_COUNT=0); REG index<REG_COUNT-1 -> index+1, else MEM index 0; MEM index<MEM_WORDS-1 -> index+1, else DONE; non-DONE targets go to SETUP.
REQ-026 DONE: o_done=1, o_busy=0 for one cycle; go to IDLE.
REQ-027 Latency: i_start sampled at edge T0 -> o_wr high in cycle T0+3; completion edge sampled at Tk -> next o_wr high at Tk+4.
REQ-028 i_start while not IDLE SHALL be ignored and not queued.
REQ-029 o_wr SHALL never be high while in WAIT after its first cycle; at most one outstanding word.

Reset
REQ-030 i_reset SHALL force IDLE, section=PC, index=0, o_wr=0, o_wr_data=0, address outputs=0, o_busy=0, o_done=0, finished-edge register=0.
REQ-031 Reset mid-frame SHALL abort without o_done; next i_start restarts from i_pc.
REQ-032 i_reset SHALL override i_start in the same cycle.

Structure
REQ-033 State and section encodings SHALL be localparams in the shared debug package, reused by the debug unit top.
REQ-034 No sub-module; the serializer is instantiated beside this block by the debug unit top, not inside it.

Verification
REQ-035 REG_COUNT=2, MEM_WORDS=2, i_pc=0x00000040, regs=0x11111111/0x22222222, mem=0xAAAAAAAA/0xBBBBBBBB, serializer model finishing 10 cycles after o_wr -> o_wr_data sequence 0x40, 0x11111111, 0x22222222, 0xAAAAAAAA, 0xBBBBBBBB, then single o_done.
REQ-036 i_start at edge T0 -> o_wr high at T0+3, o_busy high from T0+1 through last NEXT.
REQ-037 i_wr_finished held high from previous frame at start -> no early advance; first word held until its own 0->1 edge.
REQ-038 i_start pulsed during WAIT of word 2 -> frame unchanged, exactly 5 o_wr pulses, one o_done.
REQ-039 i_reset asserted during WAIT of word 3 -> next cycle o_wr=0, o_busy=0, no o_done; new i_start resends from 0x40.
REQ-040 Serializer stall (finished edge delayed 200 cycles) -> o_wr_data stable for all 200 cycles, no extra o_wr.
